// File: rtl/hp_burst_sched.sv
// Burst-request arbiter for the shared AXI3 HP0 address path: read priority, write anti-starvation,
// per-direction outstanding limit. Optional statistics counters are enabled by defining HP_SCHED_STATS_EN.
module hp_burst_sched #(
   parameter int BURST_LEN  = 16,
   parameter int MAX_OUT    = 4,
   parameter int STARVE_MAX = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        rd_req_valid_i,
   input  logic [31:0] rd_req_addr_i,
   output logic        rd_req_ready_o,
   input  logic        wr_req_valid_i,
   input  logic [31:0] wr_req_addr_i,
   output logic        wr_req_ready_o,
   output logic        m_axi_arvalid_o,
   input  logic        m_axi_arready_i,
   output logic [31:0] m_axi_araddr_o,
   output logic [3:0]  m_axi_arlen_o,
   output logic        m_axi_awvalid_o,
   input  logic        m_axi_awready_i,
   output logic [31:0] m_axi_awaddr_o,
   output logic [3:0]  m_axi_awlen_o,
   input  logic        m_axi_rvalid_i,
   input  logic        m_axi_rready_i,
   input  logic        m_axi_rlast_i,
   input  logic        m_axi_bvalid_i,
   input  logic        m_axi_bready_i,
   output logic [2:0]  rd_out_o,
   output logic [2:0]  wr_out_o,
`ifdef HP_SCHED_STATS_EN
   output logic [31:0] rd_grants_o,
   output logic [31:0] wr_grants_o,
   output logic [31:0] stall_cycles_o,
`endif
   output logic        busy_o
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [2:0]    MAX_OUT_C = 3'(MAX_OUT);
   localparam logic [SW-1:0] STARVE_C  = SW'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, ISSUE_RD, ISSUE_WR} state_t;

   state_t        state_q, state_d;
   logic [31:0]   ar_addr_q, ar_addr_d;
   logic [31:0]   aw_addr_q, aw_addr_d;
   logic [2:0]    rd_out_q, rd_out_d;
   logic [2:0]    wr_out_q, wr_out_d;
   logic [SW-1:0] starve_q, starve_d;

   logic rd_elig, wr_elig, grant_rd, grant_wr;
   logic ar_hs, aw_hs, rd_cpl, wr_cpl;

   assign rd_elig = rd_req_valid_i && (rd_out_q < MAX_OUT_C);
   assign wr_elig = wr_req_valid_i && (wr_out_q < MAX_OUT_C);
   assign ar_hs   = (state_q == ISSUE_RD) && m_axi_arready_i;
   assign aw_hs   = (state_q == ISSUE_WR) && m_axi_awready_i;
   assign rd_cpl  = m_axi_rvalid_i && m_axi_rready_i && m_axi_rlast_i;
   assign wr_cpl  = m_axi_bvalid_i && m_axi_bready_i;

   always_comb begin
      state_d   = state_q;
      ar_addr_d = ar_addr_q;
      aw_addr_d = aw_addr_q;
      grant_rd  = 1'b0;
      grant_wr  = 1'b0;
      case (state_q)
         IDLE: begin
            // Grants are combinational, so they are suppressed while reset is held.
            if (rst_ni) begin
               if (wr_elig && ((starve_q == STARVE_C) || !rd_elig)) begin
                  grant_wr  = 1'b1;
                  aw_addr_d = wr_req_addr_i;
                  state_d   = ISSUE_WR;
               end else if (rd_elig) begin
                  grant_rd  = 1'b1;
                  ar_addr_d = rd_req_addr_i;
                  state_d   = ISSUE_RD;
               end
            end
         end
         ISSUE_RD: if (m_axi_arready_i) state_d = IDLE;
         ISSUE_WR: if (m_axi_awready_i) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // A completion seen while the counter is already 0 is dropped, never wrapping below zero.
   always_comb begin
      rd_out_d = rd_out_q;
      if (ar_hs && !(rd_cpl && (rd_out_q != 3'd0)))
         rd_out_d = rd_out_q + 3'd1;
      else if (!ar_hs && rd_cpl && (rd_out_q != 3'd0))
         rd_out_d = rd_out_q - 3'd1;

      wr_out_d = wr_out_q;
      if (aw_hs && !(wr_cpl && (wr_out_q != 3'd0)))
         wr_out_d = wr_out_q + 3'd1;
      else if (!aw_hs && wr_cpl && (wr_out_q != 3'd0))
         wr_out_d = wr_out_q - 3'd1;

      starve_d = starve_q;
      if (!wr_req_valid_i || grant_wr)
         starve_d = '0;
      else if (starve_q != STARVE_C)
         starve_d = starve_q + SW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         ar_addr_q <= '0;
         aw_addr_q <= '0;
         rd_out_q  <= '0;
         wr_out_q  <= '0;
         starve_q  <= '0;
      end else begin
         state_q   <= state_d;
         ar_addr_q <= ar_addr_d;
         aw_addr_q <= aw_addr_d;
         rd_out_q  <= rd_out_d;
         wr_out_q  <= wr_out_d;
         starve_q  <= starve_d;
      end
   end

`ifdef HP_SCHED_STATS_EN
   logic [31:0] rd_grants_q, wr_grants_q, stall_q;
   logic        stall;

   assign stall = ((state_q == ISSUE_RD) && !m_axi_arready_i) ||
                  ((state_q == ISSUE_WR) && !m_axi_awready_i);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_grants_q <= '0;
         wr_grants_q <= '0;
         stall_q     <= '0;
      end else begin
         if (grant_rd) rd_grants_q <= rd_grants_q + 32'd1;
         if (grant_wr) wr_grants_q <= wr_grants_q + 32'd1;
         if (stall)    stall_q     <= stall_q + 32'd1;
      end
   end

   assign rd_grants_o    = rd_grants_q;
   assign wr_grants_o    = wr_grants_q;
   assign stall_cycles_o = stall_q;
`endif

   assign rd_req_ready_o  = grant_rd;
   assign wr_req_ready_o  = grant_wr;
   assign m_axi_arvalid_o = (state_q == ISSUE_RD);
   assign m_axi_awvalid_o = (state_q == ISSUE_WR);
   assign m_axi_araddr_o  = ar_addr_q;
   assign m_axi_awaddr_o  = aw_addr_q;
   assign m_axi_arlen_o   = 4'(BURST_LEN - 1);
   assign m_axi_awlen_o   = 4'(BURST_LEN - 1);
   assign rd_out_o        = rd_out_q;
   assign wr_out_o        = wr_out_q;
   assign busy_o          = (state_q != IDLE) || (rd_out_q != 3'd0) || (wr_out_q != 3'd0);

endmodule

// File: tb/tb_hp_burst_sched.sv
// Randomized bench for hp_burst_sched: a transaction-level model (in-flight queues, pending issue,
// write wait time) predicts every output each cycle; directed phases steer toward the corner cases.
module tb_hp_burst_sched;

  localparam int BURST_LEN  = 16;
  localparam int MAX_OUT    = 4;
  localparam int STARVE_MAX = 64;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        rd_req_valid_i, wr_req_valid_i;
  logic [31:0] rd_req_addr_i, wr_req_addr_i;
  logic        rd_req_ready_o, wr_req_ready_o;
  logic        m_axi_arvalid_o, m_axi_arready_i, m_axi_awvalid_o, m_axi_awready_i;
  logic [31:0] m_axi_araddr_o, m_axi_awaddr_o;
  logic [3:0]  m_axi_arlen_o, m_axi_awlen_o;
  logic        m_axi_rvalid_i, m_axi_rready_i, m_axi_rlast_i;
  logic        m_axi_bvalid_i, m_axi_bready_i;
  logic [2:0]  rd_out_o, wr_out_o;
  logic        busy_o;
`ifdef HP_SCHED_STATS_EN
  logic [31:0] rd_grants_o, wr_grants_o, stall_cycles_o;
`endif

  always #5 clk = ~clk;

  hp_burst_sched #(.BURST_LEN(BURST_LEN), .MAX_OUT(MAX_OUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_addr_i(rd_req_addr_i), .rd_req_ready_o(rd_req_ready_o),
    .wr_req_valid_i(wr_req_valid_i), .wr_req_addr_i(wr_req_addr_i), .wr_req_ready_o(wr_req_ready_o),
    .m_axi_arvalid_o(m_axi_arvalid_o), .m_axi_arready_i(m_axi_arready_i),
    .m_axi_araddr_o(m_axi_araddr_o), .m_axi_arlen_o(m_axi_arlen_o),
    .m_axi_awvalid_o(m_axi_awvalid_o), .m_axi_awready_i(m_axi_awready_i),
    .m_axi_awaddr_o(m_axi_awaddr_o), .m_axi_awlen_o(m_axi_awlen_o),
    .m_axi_rvalid_i(m_axi_rvalid_i), .m_axi_rready_i(m_axi_rready_i), .m_axi_rlast_i(m_axi_rlast_i),
    .m_axi_bvalid_i(m_axi_bvalid_i), .m_axi_bready_i(m_axi_bready_i),
    .rd_out_o(rd_out_o), .wr_out_o(wr_out_o),
`ifdef HP_SCHED_STATS_EN
    .rd_grants_o(rd_grants_o), .wr_grants_o(wr_grants_o), .stall_cycles_o(stall_cycles_o),
`endif
    .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which address channel is waiting, bursts in flight, write wait time.
  int          m_pend;       // 0 none, 1 read address waiting, 2 write address waiting
  logic [31:0] m_ar_addr, m_aw_addr;
  logic [31:0] rd_fly[$];
  logic [31:0] wr_fly[$];
  int          m_wait;
  int          m_rd_grants, m_wr_grants, m_stalls;
  int          starve_wins;

  // Stimulus knobs (percent) and request-hold bookkeeping.
  int p_rd, p_wr, p_ar, p_aw, p_rl, p_b, p_rst;
  bit force_rst, rd_hold, wr_hold;

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FF80;
    if ($urandom_range(0, 15) == 0) a[6:0] = 7'($urandom_range(1, 127));
    return a;
  endfunction

  task automatic drive();
    logic [2:0] r3;
    rst_ni = !(force_rst || pct(p_rst));
    if (!rd_hold) begin
      rd_req_valid_i = pct(p_rd);
      rd_req_addr_i  = rand_addr();
    end
    if (!wr_hold) begin
      wr_req_valid_i = pct(p_wr);
      wr_req_addr_i  = rand_addr();
    end
    m_axi_arready_i = pct(p_ar);
    m_axi_awready_i = pct(p_aw);
    if (pct(p_rl)) r3 = 3'b111;
    else           r3 = 3'($urandom_range(0, 6));
    {m_axi_rvalid_i, m_axi_rready_i, m_axi_rlast_i} = r3;
    if (pct(p_b)) {m_axi_bvalid_i, m_axi_bready_i} = 2'b11;
    else          {m_axi_bvalid_i, m_axi_bready_i} = 2'($urandom_range(0, 2));
  endtask

  task automatic eval_cycle();
    bit rd_ok, wr_ok, gr, gw, ar_done, aw_done;
    rd_ok = rd_req_valid_i && (rd_fly.size() < MAX_OUT);
    wr_ok = wr_req_valid_i && (wr_fly.size() < MAX_OUT);
    gr = 1'b0;
    gw = 1'b0;
    if (rst_ni && m_pend == 0) begin
      if (wr_ok && (m_wait >= STARVE_MAX || !rd_ok)) gw = 1'b1;
      else if (rd_ok) gr = 1'b1;
    end
    if (gw && rd_ok) starve_wins++;

    check_val("rd_ready", 32'(rd_req_ready_o), 32'(gr));
    check_val("wr_ready", 32'(wr_req_ready_o), 32'(gw));
    check_val("arvalid", 32'(m_axi_arvalid_o), 32'(m_pend == 1));
    check_val("awvalid", 32'(m_axi_awvalid_o), 32'(m_pend == 2));
    check_val("araddr", m_axi_araddr_o, m_ar_addr);
    check_val("awaddr", m_axi_awaddr_o, m_aw_addr);
    check_val("arlen", 32'(m_axi_arlen_o), BURST_LEN - 1);
    check_val("awlen", 32'(m_axi_awlen_o), BURST_LEN - 1);
    check_val("rd_out", 32'(rd_out_o), rd_fly.size());
    check_val("wr_out", 32'(wr_out_o), wr_fly.size());
    check_val("busy", 32'(busy_o), 32'(m_pend != 0 || rd_fly.size() != 0 || wr_fly.size() != 0));
`ifdef HP_SCHED_STATS_EN
    check_val("rd_grants", rd_grants_o, m_rd_grants);
    check_val("wr_grants", wr_grants_o, m_wr_grants);
    check_val("stalls", stall_cycles_o, m_stalls);
`endif

    if (!rst_ni) begin
      m_pend = 0; m_ar_addr = '0; m_aw_addr = '0;
      rd_fly.delete(); wr_fly.delete();
      m_wait = 0; m_rd_grants = 0; m_wr_grants = 0; m_stalls = 0;
    end else begin
      ar_done = (m_pend == 1) && m_axi_arready_i;
      aw_done = (m_pend == 2) && m_axi_awready_i;
      if ((m_pend == 1 && !m_axi_arready_i) || (m_pend == 2 && !m_axi_awready_i)) m_stalls++;
      if (m_axi_rvalid_i && m_axi_rready_i && m_axi_rlast_i && rd_fly.size() > 0) void'(rd_fly.pop_front());
      if (m_axi_bvalid_i && m_axi_bready_i && wr_fly.size() > 0) void'(wr_fly.pop_front());
      if (ar_done) begin rd_fly.push_back(m_ar_addr); m_pend = 0; end
      if (aw_done) begin wr_fly.push_back(m_aw_addr); m_pend = 0; end
      if (!wr_req_valid_i || gw) m_wait = 0;
      else if (m_wait < STARVE_MAX) m_wait++;
      if (gr) begin m_pend = 1; m_ar_addr = rd_req_addr_i; m_rd_grants++; end
      if (gw) begin m_pend = 2; m_aw_addr = wr_req_addr_i; m_wr_grants++; end
    end
    rd_hold = rd_req_valid_i && !gr;
    wr_hold = wr_req_valid_i && !gw;
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #1;
    drive();
    #4;
    eval_cycle();
  endtask

  task automatic knobs(input int rd, input int wr, input int ar, input int aw, input int rl, input int b);
    p_rd = rd; p_wr = wr; p_ar = ar; p_aw = aw; p_rl = rl; p_b = b;
  endtask

  initial begin
    int budget;
    rst_ni = 1'b0;
    rd_req_valid_i = 0; wr_req_valid_i = 0; rd_req_addr_i = '0; wr_req_addr_i = '0;
    m_axi_arready_i = 0; m_axi_awready_i = 0;
    m_axi_rvalid_i = 0; m_axi_rready_i = 0; m_axi_rlast_i = 0;
    m_axi_bvalid_i = 0; m_axi_bready_i = 0;
    m_pend = 0; m_ar_addr = '0; m_aw_addr = '0; m_wait = 0;
    m_rd_grants = 0; m_wr_grants = 0; m_stalls = 0; starve_wins = 0;
    rd_hold = 0; wr_hold = 0; p_rst = 0;

    // Reset
    force_rst = 1;
    knobs(0, 0, 0, 0, 0, 0);
    repeat (3) run_cycle();
    force_rst = 0;

    // Outstanding limit: reads only, no completions
    knobs(100, 0, 100, 0, 0, 0);
    repeat (20) run_cycle();
    check_val("limit_full", 32'(rd_out_o), MAX_OUT);
    knobs(100, 0, 100, 0, 100, 0);
    run_cycle();
    knobs(100, 0, 100, 0, 0, 0);
    repeat (4) run_cycle();
    check_val("limit_refill", 32'(rd_out_o), MAX_OUT);

    // Priority and starvation: both requesters always valid, completions flowing
    knobs(100, 100, 100, 100, 100, 100);
    repeat (400) run_cycle();
    check_val("starve_win_seen", 32'(starve_wins > 0), 1);

    // Write backpressure
    rd_hold = 0; wr_hold = 0;
    knobs(0, 100, 100, 0, 100, 100);
    repeat (15) run_cycle();
    knobs(0, 100, 100, 100, 100, 100);
    repeat (4) run_cycle();

    // Reset mid-operation with three reads in flight and a fourth waiting on arready
    rd_hold = 0; wr_hold = 0;
    knobs(0, 0, 100, 100, 100, 100);
    repeat (10) run_cycle();
    knobs(100, 0, 100, 0, 0, 0);
    budget = 50;
    while (!(rd_fly.size() == 3 && m_pend == 0) && budget > 0) begin run_cycle(); budget--; end
    check_val("timeout_fill3", 32'(budget > 0), 1);
    knobs(100, 0, 0, 0, 0, 0);
    budget = 10;
    while (m_pend != 1 && budget > 0) begin run_cycle(); budget--; end
    check_val("timeout_issue_rd", 32'(budget > 0), 1);
    force_rst = 1;
    run_cycle();
    force_rst = 0;
    rd_hold = 0;
    knobs(0, 0, 0, 0, 100, 100);
    repeat (5) run_cycle();
    check_val("rst_rd_out", 32'(rd_out_o), 0);
    check_val("rst_arvalid", 32'(m_axi_arvalid_o), 0);

    // Random traffic with occasional resets
    knobs(50, 50, 50, 50, 20, 20);
    p_rst = 1;
    repeat (3000) run_cycle();
    p_rst = 0;

    // Drain
    rd_hold = 0; wr_hold = 0;
    knobs(0, 0, 100, 100, 100, 100);
    repeat (20) run_cycle();
    check_val("drain_busy", 32'(busy_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
